// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command sequencer: opcodes, FSM states,
// serializer phases and the fixed operand register addresses.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OP_A,
        S_OP_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_LO,
        S_TX_HI
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_LO,
        PH_HI
    } tx_phase_t;

endpackage

// File: rtl/sys_tx_serializer.sv
// Holds a one- or two-byte response and pushes it low byte first into the
// TX FIFO, stalling without loss while the FIFO reports full.
module sys_tx_serializer
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    two_bytes,
    input  logic [2*DATA_WIDTH-1:0] load_data,
    input  logic                    fifo_full,
    output logic [DATA_WIDTH-1:0]   fifo_wr_data,
    output logic                    fifo_wr_inc,
    output logic                    busy,
    output logic                    hi_phase
);

    tx_phase_t               phase;
    logic [2*DATA_WIDTH-1:0] hold;
    logic                    two_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase        <= PH_IDLE;
            hold         <= '0;
            two_q        <= 1'b0;
            fifo_wr_data <= '0;
            fifo_wr_inc  <= 1'b0;
        end else begin
            fifo_wr_inc <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (load) begin
                        hold  <= load_data;
                        two_q <= two_bytes;
                        phase <= PH_LO;
                    end
                end
                PH_LO: begin
                    if (!fifo_full) begin
                        fifo_wr_inc  <= 1'b1;
                        fifo_wr_data <= hold[DATA_WIDTH-1:0];
                        phase        <= two_q ? PH_HI : PH_IDLE;
                    end
                end
                PH_HI: begin
                    if (!fifo_full) begin
                        fifo_wr_inc  <= 1'b1;
                        fifo_wr_data <= hold[2*DATA_WIDTH-1:DATA_WIDTH];
                        phase        <= PH_IDLE;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

    assign busy     = (phase != PH_IDLE);
    assign hi_phase = (phase == PH_HI);

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Byte-framed command sequencer driving register file, ALU and TX FIFO.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic                    RF_WrEn,
    output logic                    RF_RdEn,
    output logic [ADDR_WIDTH-1:0]   RF_Address,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    output logic                    ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
    output logic                    FIFO_WR_INC,
    input  logic                    FIFO_FULL,
    output logic                    ERR_CMD
);

    state_t                  state;
    logic                    ser_load;
    logic                    ser_two;
    logic [2*DATA_WIDTH-1:0] ser_data;
    logic                    ser_busy;
    logic                    ser_hi;
    logic                    timeout;

    // Result hand-off happens in the same cycle the valid pulse is seen.
    always_comb begin
        ser_load = 1'b0;
        ser_two  = 1'b0;
        ser_data = '0;
        if (state == S_RD_WAIT && RF_RdData_VLD) begin
            ser_load = 1'b1;
            ser_data = {{DATA_WIDTH{1'b0}}, RF_RdData};
        end else if (state == S_ALU_WAIT && ALU_OUT_VLD) begin
            ser_load = 1'b1;
            ser_two  = 1'b1;
            ser_data = ALU_OUT;
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            arg_state;

    assign arg_state = (state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
                                      S_OP_A, S_OP_B, S_ALU_FUN});
    assign timeout   = arg_state && !RX_D_VLD &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            to_cnt <= '0;
        else if (!arg_state || RX_D_VLD || timeout)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    // Without the counter the timeout length has no effect.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            ERR_CMD     <= 1'b0;
        end else begin
            RF_WrEn <= 1'b0;
            RF_RdEn <= 1'b0;
            ALU_EN  <= 1'b0;
            ERR_CMD <= 1'b0;
            if (timeout) begin
                ERR_CMD <= 1'b1;
                state   <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (RX_D_VLD) begin
                            case (RX_P_DATA)
                                CMD_RF_WR:   state <= S_WR_ADDR;
                                CMD_RF_RD:   state <= S_RD_ADDR;
                                CMD_ALU_OP:  state <= S_OP_A;
                                CMD_ALU_NOP: state <= S_ALU_FUN;
                                default:     ERR_CMD <= 1'b1;
                            endcase
                        end
                    end
                    S_WR_ADDR: begin
                        if (RX_D_VLD) begin
                            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state      <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        if (RX_D_VLD) begin
                            RF_WrData <= RX_P_DATA;
                            RF_WrEn   <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_RD_ADDR: begin
                        if (RX_D_VLD) begin
                            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            RF_RdEn    <= 1'b1;
                            state      <= S_RD_WAIT;
                        end
                    end
                    S_RD_WAIT: begin
                        if (RX_D_VLD)
                            ERR_CMD <= 1'b1;
                        if (RF_RdData_VLD)
                            state <= S_TX_LO;
                    end
                    S_OP_A: begin
                        if (RX_D_VLD) begin
                            RF_Address <= ADDR_WIDTH'(OPA_ADDR);
                            RF_WrData  <= RX_P_DATA;
                            RF_WrEn    <= 1'b1;
                            state      <= S_OP_B;
                        end
                    end
                    S_OP_B: begin
                        if (RX_D_VLD) begin
                            RF_Address <= ADDR_WIDTH'(OPB_ADDR);
                            RF_WrData  <= RX_P_DATA;
                            RF_WrEn    <= 1'b1;
                            state      <= S_ALU_FUN;
                        end
                    end
                    S_ALU_FUN: begin
                        if (RX_D_VLD) begin
                            ALU_FUN     <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
                            ALU_EN      <= 1'b1;
                            CLK_GATE_EN <= 1'b1;
                            state       <= S_ALU_WAIT;
                        end
                    end
                    S_ALU_WAIT: begin
                        if (RX_D_VLD)
                            ERR_CMD <= 1'b1;
                        if (ALU_OUT_VLD) begin
                            CLK_GATE_EN <= 1'b0;
                            state       <= S_TX_LO;
                        end
                    end
                    // The serializer owns the push timing; follow its phase.
                    S_TX_LO: begin
                        if (RX_D_VLD)
                            ERR_CMD <= 1'b1;
                        if (!ser_busy)
                            state <= S_IDLE;
                        else if (ser_hi)
                            state <= S_TX_HI;
                    end
                    S_TX_HI: begin
                        if (RX_D_VLD)
                            ERR_CMD <= 1'b1;
                        if (!ser_busy)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    sys_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_serializer (
        .clk          (CLK),
        .rst          (RST),
        .load         (ser_load),
        .two_bytes    (ser_two),
        .load_data    (ser_data),
        .fifo_full    (FIFO_FULL),
        .fifo_wr_data (FIFO_WR_DATA),
        .fifo_wr_inc  (FIFO_WR_INC),
        .busy         (ser_busy),
        .hi_phase     (ser_hi)
    );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl: a per-cycle vector table plus hand-written
// sequences for FIFO back-pressure and mid-command reset.
module tb_sys_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        RF_WrEn, RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_VLD;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        CLK_GATE_EN;
    logic [7:0]  FIFO_WR_DATA;
    logic        FIFO_WR_INC;
    logic        FIFO_FULL;
    logic        ERR_CMD;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    typedef struct {
        bit          vld;
        logic [7:0]  data;
        bit          rdv;
        logic [7:0]  rdd;
        bit          aluv;
        logic [15:0] aluo;
        bit          full;
        bit          wr;
        bit          rd;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        bit          aen;
        logic [3:0]  afun;
        bit          gate;
        bit          inc;
        logic [7:0]  fdata;
        bit          err;
    } vec_t;

    vec_t tbl [31];

    sys_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VLD      (RX_D_VLD),
        .RF_WrEn       (RF_WrEn),
        .RF_RdEn       (RF_RdEn),
        .RF_Address    (RF_Address),
        .RF_WrData     (RF_WrData),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_EN        (ALU_EN),
        .ALU_FUN       (ALU_FUN),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VLD   (ALU_OUT_VLD),
        .CLK_GATE_EN   (CLK_GATE_EN),
        .FIFO_WR_DATA  (FIFO_WR_DATA),
        .FIFO_WR_INC   (FIFO_WR_INC),
        .FIFO_FULL     (FIFO_FULL),
        .ERR_CMD       (ERR_CMD)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] outs();
        return {2'b00, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN,
                ALU_FUN, CLK_GATE_EN, FIFO_WR_INC, FIFO_WR_DATA, ERR_CMD};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         pushes;
        logic [7:0] got [$];
        logic [7:0] g0, g1;

        //               vld byte   rdv rdd    aluv aluo      full  wr rd addr  wdata  aen afun  gate inc fdata  err
        tbl[0]  = '{Y, 8'hAA, N, 8'h00, N, 16'h0000, N,  N, N, 4'h0, 8'h00, N, 4'h0, N, N, 8'h00, N};
        tbl[1]  = '{Y, 8'h05, N, 8'h00, N, 16'h0000, N,  N, N, 4'h5, 8'h00, N, 4'h0, N, N, 8'h00, N};
        tbl[2]  = '{Y, 8'h3C, N, 8'h00, N, 16'h0000, N,  Y, N, 4'h5, 8'h3C, N, 4'h0, N, N, 8'h00, N};
        tbl[3]  = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h5, 8'h3C, N, 4'h0, N, N, 8'h00, N};
        tbl[4]  = '{Y, 8'hBB, N, 8'h00, N, 16'h0000, N,  N, N, 4'h5, 8'h3C, N, 4'h0, N, N, 8'h00, N};
        tbl[5]  = '{Y, 8'h05, N, 8'h00, N, 16'h0000, N,  N, Y, 4'h5, 8'h3C, N, 4'h0, N, N, 8'h00, N};
        tbl[6]  = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h5, 8'h3C, N, 4'h0, N, N, 8'h00, N};
        tbl[7]  = '{N, 8'h00, Y, 8'h3C, N, 16'h0000, N,  N, N, 4'h5, 8'h3C, N, 4'h0, N, N, 8'h00, N};
        tbl[8]  = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h5, 8'h3C, N, 4'h0, N, Y, 8'h3C, N};
        tbl[9]  = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h5, 8'h3C, N, 4'h0, N, N, 8'h3C, N};
        tbl[10] = '{Y, 8'hCC, N, 8'h00, N, 16'h0000, N,  N, N, 4'h5, 8'h3C, N, 4'h0, N, N, 8'h3C, N};
        tbl[11] = '{Y, 8'h07, N, 8'h00, N, 16'h0000, N,  Y, N, 4'h0, 8'h07, N, 4'h0, N, N, 8'h3C, N};
        tbl[12] = '{Y, 8'h06, N, 8'h00, N, 16'h0000, N,  Y, N, 4'h1, 8'h06, N, 4'h0, N, N, 8'h3C, N};
        tbl[13] = '{Y, 8'h02, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, Y, 4'h2, Y, N, 8'h3C, N};
        tbl[14] = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h2, Y, N, 8'h3C, N};
        tbl[15] = '{N, 8'h00, N, 8'h00, Y, 16'h002A, N,  N, N, 4'h1, 8'h06, N, 4'h2, N, N, 8'h3C, N};
        tbl[16] = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h2, N, Y, 8'h2A, N};
        tbl[17] = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h2, N, Y, 8'h00, N};
        tbl[18] = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h2, N, N, 8'h00, N};
        tbl[19] = '{Y, 8'h55, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h2, N, N, 8'h00, Y};
        tbl[20] = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h2, N, N, 8'h00, N};
        tbl[21] = '{Y, 8'hDD, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h2, N, N, 8'h00, N};
        tbl[22] = '{Y, 8'h01, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, Y, 4'h1, Y, N, 8'h00, N};
        tbl[23] = '{Y, 8'h77, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h1, Y, N, 8'h00, Y};
        tbl[24] = '{N, 8'h00, N, 8'h00, Y, 16'h1234, Y,  N, N, 4'h1, 8'h06, N, 4'h1, N, N, 8'h00, N};
        tbl[25] = '{N, 8'h00, N, 8'h00, N, 16'h0000, Y,  N, N, 4'h1, 8'h06, N, 4'h1, N, N, 8'h00, N};
        tbl[26] = '{N, 8'h00, N, 8'h00, N, 16'h0000, Y,  N, N, 4'h1, 8'h06, N, 4'h1, N, N, 8'h00, N};
        tbl[27] = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h1, N, Y, 8'h34, N};
        tbl[28] = '{N, 8'h00, N, 8'h00, N, 16'h0000, Y,  N, N, 4'h1, 8'h06, N, 4'h1, N, N, 8'h34, N};
        tbl[29] = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h1, N, Y, 8'h12, N};
        tbl[30] = '{N, 8'h00, N, 8'h00, N, 16'h0000, N,  N, N, 4'h1, 8'h06, N, 4'h1, N, N, 8'h12, N};

        RST = 1'b1;
        RX_P_DATA = '0; RX_D_VLD = 1'b0;
        RF_RdData = '0; RF_RdData_VLD = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
        FIFO_FULL = 1'b0;
        tick();
        tick();
        check("reset_outputs", outs(), 32'h0);
        RST = 1'b0;

        for (int i = 0; i < 31; i++) begin
            RX_P_DATA     = tbl[i].data;
            RX_D_VLD      = tbl[i].vld;
            RF_RdData     = tbl[i].rdd;
            RF_RdData_VLD = tbl[i].rdv;
            ALU_OUT       = tbl[i].aluo;
            ALU_OUT_VLD   = tbl[i].aluv;
            FIFO_FULL     = tbl[i].full;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {2'b00, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].aen,
                   tbl[i].afun, tbl[i].gate, tbl[i].inc, tbl[i].fdata, tbl[i].err});
        end
        RX_D_VLD = 1'b0; RF_RdData_VLD = 1'b0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;

        // FIFO held full for 10 cycles after the ALU result.
        send_byte(8'hDD);
        send_byte(8'h09);
        check("nop_alu_en", {ALU_EN, ALU_FUN, CLK_GATE_EN}, {1'b1, 4'h9, 1'b1});
        tick();
        FIFO_FULL   = 1'b1;
        ALU_OUT     = 16'hBEEF;
        ALU_OUT_VLD = 1'b1;
        check("gate_at_result", CLK_GATE_EN, 1'b1);
        tick();
        ALU_OUT_VLD = 1'b0;
        check("gate_after_result", CLK_GATE_EN, 1'b0);
        pushes = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (FIFO_WR_INC) pushes++;
        end
        check("no_push_while_full", pushes, 0);
        FIFO_FULL = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (FIFO_WR_INC) got.push_back(FIFO_WR_DATA);
        end
        g0 = (got.size() > 0) ? got[0] : 8'hxx;
        g1 = (got.size() > 1) ? got[1] : 8'hxx;
        check("push_count_after_release", got.size(), 2);
        check("push_lo_byte", g0, 8'hEF);
        check("push_hi_byte", g1, 8'hBE);

        // Reset while waiting for the ALU result.
        send_byte(8'hDD);
        send_byte(8'h03);
        tick();
        check("pre_reset_gate", {CLK_GATE_EN, ALU_FUN}, {1'b1, 4'h3});
        #2 RST = 1'b1;
        #1 check("async_reset_outputs", outs(), 32'h0);
        tick();
        check("held_reset_outputs", outs(), 32'h0);
        RST = 1'b0;
        ALU_OUT     = 16'h5555;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        check("stale_result_ignored", outs(), 32'h0);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'hFF);
        check("post_reset_write", {RF_WrEn, RF_Address, RF_WrData, ERR_CMD},
              {1'b1, 4'h1, 8'hFF, 1'b0});
        pushes = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (FIFO_WR_INC || ERR_CMD) pushes++;
        end
        check("no_stale_push_or_err", pushes, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
